// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the door alarm controller: state codes, interval
// selector codes and the default interval lengths in seconds.
package alarm_controller_pkg;

   typedef enum logic [2:0] {
      S_ARMED      = 3'd0,
      S_TRIGGERED  = 3'd1,
      S_SOUND      = 3'd2,
      S_ALARM_HOLD = 3'd3,
      S_DISARMED   = 3'd4,
      S_WAIT_OPEN  = 3'd5,
      S_WAIT_CLOSE = 3'd6,
      S_ARM_DELAY  = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      SEL_ARM       = 2'd0,
      SEL_DRIVER    = 2'd1,
      SEL_PASSENGER = 2'd2,
      SEL_ALARM_ON  = 2'd3
   } param_sel_t;

   localparam int unsigned INTERVAL_W          = 4;
   localparam int unsigned DEF_T_ARM_DELAY     = 6;
   localparam int unsigned DEF_T_DRIVER_DELAY  = 8;
   localparam int unsigned DEF_T_PASSENGER_DELAY = 15;
   localparam int unsigned DEF_T_ALARM_ON      = 10;

   // Siren is audible only while actively sounding or holding after doors close.
   function automatic logic siren_for(input state_t s);
      return (s == S_SOUND) || (s == S_ALARM_HOLD);
   endfunction

endpackage

// File: rtl/alarm_controller_time_parameters.sv
// Interval register file: four programmable countdown lengths, restored to
// their parameter defaults on reset and rewritten by the reprogram strobe.
module time_parameters
   import alarm_controller_pkg::*;
#(
   parameter int unsigned T_ARM_DELAY       = DEF_T_ARM_DELAY,
   parameter int unsigned T_DRIVER_DELAY    = DEF_T_DRIVER_DELAY,
   parameter int unsigned T_PASSENGER_DELAY = DEF_T_PASSENGER_DELAY,
   parameter int unsigned T_ALARM_ON        = DEF_T_ALARM_ON
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  reprogram,
   input  logic [1:0]            timeParamSel,
   input  logic [INTERVAL_W-1:0] timeValue,
   output logic [INTERVAL_W-1:0] armInterval,
   output logic [INTERVAL_W-1:0] driverInterval,
   output logic [INTERVAL_W-1:0] passengerInterval,
   output logic [INTERVAL_W-1:0] alarmOnInterval
);

   logic [INTERVAL_W-1:0] r_arm;
   logic [INTERVAL_W-1:0] r_driver;
   logic [INTERVAL_W-1:0] r_passenger;
   logic [INTERVAL_W-1:0] r_alarm_on;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_arm       <= INTERVAL_W'(T_ARM_DELAY);
         r_driver    <= INTERVAL_W'(T_DRIVER_DELAY);
         r_passenger <= INTERVAL_W'(T_PASSENGER_DELAY);
         r_alarm_on  <= INTERVAL_W'(T_ALARM_ON);
      end else if (reprogram) begin
         case (param_sel_t'(timeParamSel))
            SEL_ARM:       r_arm       <= timeValue;
            SEL_DRIVER:    r_driver    <= timeValue;
            SEL_PASSENGER: r_passenger <= timeValue;
            SEL_ALARM_ON:  r_alarm_on  <= timeValue;
            default:       r_arm       <= r_arm;
         endcase
      end
   end

   assign armInterval       = r_arm;
   assign driverInterval    = r_driver;
   assign passengerInterval = r_passenger;
   assign alarmOnInterval   = r_alarm_on;

endmodule

// File: rtl/alarm_controller.sv
// Vehicle door alarm: arms after the driver leaves, counts down on door
// entry, sounds the siren, and disarms with the ignition key.
module alarm_controller
   import alarm_controller_pkg::*;
#(
   parameter int unsigned T_ARM_DELAY       = DEF_T_ARM_DELAY,
   parameter int unsigned T_DRIVER_DELAY    = DEF_T_DRIVER_DELAY,
   parameter int unsigned T_PASSENGER_DELAY = DEF_T_PASSENGER_DELAY,
   parameter int unsigned T_ALARM_ON        = DEF_T_ALARM_ON
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ignition,
   input  logic                  driverDoor,
   input  logic                  passengerDoor,
   input  logic                  reprogram,
   input  logic [1:0]            timeParamSel,
   input  logic [INTERVAL_W-1:0] timeValue,
   input  logic                  expired,
   input  logic                  blink1Hz,
   output logic                  startTimer,
   output logic [INTERVAL_W-1:0] value,
   output logic                  siren,
   output logic                  statusIndicator,
   output logic [2:0]            state
);

   logic [INTERVAL_W-1:0] w_arm_iv;
   logic [INTERVAL_W-1:0] w_driver_iv;
   logic [INTERVAL_W-1:0] w_passenger_iv;
   logic [INTERVAL_W-1:0] w_alarm_on_iv;

   state_t                r_state;
   logic                  r_start;
   logic [INTERVAL_W-1:0] r_value;
   logic                  r_siren;
   logic                  r_status;

   state_t                w_next;
   logic                  w_start;
   logic [INTERVAL_W-1:0] w_value;
   logic                  w_status;
   logic                  w_expired;
   logic                  w_any_door;

   time_parameters #(
      .T_ARM_DELAY       (T_ARM_DELAY),
      .T_DRIVER_DELAY    (T_DRIVER_DELAY),
      .T_PASSENGER_DELAY (T_PASSENGER_DELAY),
      .T_ALARM_ON        (T_ALARM_ON)
   ) u_time_parameters (
      .clock             (clock),
      .reset             (reset),
      .reprogram         (reprogram),
      .timeParamSel      (timeParamSel),
      .timeValue         (timeValue),
      .armInterval       (w_arm_iv),
      .driverInterval    (w_driver_iv),
      .passengerInterval (w_passenger_iv),
      .alarmOnInterval   (w_alarm_on_iv)
   );

   // The timer has only just been started while r_start is high, so any
   // expired seen then belongs to an abandoned countdown.
   assign w_expired  = expired && !r_start;
   assign w_any_door = driverDoor || passengerDoor;

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_value = r_value;
      if (reprogram) begin
         w_next = S_ARMED;
      end else begin
         case (r_state)
            S_ARMED: begin
               if (w_any_door) begin
                  w_next  = S_TRIGGERED;
                  w_start = 1'b1;
                  w_value = driverDoor ? w_driver_iv : w_passenger_iv;
               end
            end
            S_TRIGGERED: begin
               if (ignition)       w_next = S_DISARMED;
               else if (w_expired) w_next = S_SOUND;
            end
            S_SOUND: begin
               if (ignition) begin
                  w_next = S_DISARMED;
               end else if (!w_any_door) begin
                  w_next  = S_ALARM_HOLD;
                  w_start = 1'b1;
                  w_value = w_alarm_on_iv;
               end
            end
            S_ALARM_HOLD: begin
               if (ignition)        w_next = S_DISARMED;
               else if (w_any_door) w_next = S_SOUND;
               else if (w_expired)  w_next = S_ARMED;
            end
            S_DISARMED: begin
               if (!ignition) w_next = S_WAIT_OPEN;
            end
            S_WAIT_OPEN: begin
               if (ignition)        w_next = S_DISARMED;
               else if (driverDoor) w_next = S_WAIT_CLOSE;
            end
            S_WAIT_CLOSE: begin
               if (ignition) begin
                  w_next = S_DISARMED;
               end else if (!driverDoor) begin
                  w_next  = S_ARM_DELAY;
                  w_start = 1'b1;
                  w_value = w_arm_iv;
               end
            end
            S_ARM_DELAY: begin
               if (ignition)        w_next = S_DISARMED;
               else if (driverDoor) w_next = S_WAIT_CLOSE;
               else if (w_expired)  w_next = S_ARMED;
            end
            default: w_next = S_ARMED;
         endcase
      end
   end

   always_comb begin
      w_status = 1'b0;
      case (w_next)
         S_ARMED:                              w_status = blink1Hz;
         S_TRIGGERED, S_SOUND, S_ALARM_HOLD:   w_status = 1'b1;
         default:                              w_status = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_ARMED;
         r_start  <= 1'b0;
         r_value  <= '0;
         r_siren  <= 1'b0;
         r_status <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_start  <= w_start;
         r_value  <= w_value;
         r_siren  <= siren_for(w_next);
         r_status <= w_status;
      end
   end

   assign state           = r_state;
   assign startTimer      = r_start;
   assign value           = r_value;
   assign siren           = r_siren;
   assign statusIndicator = r_status;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed scenario bench for alarm_controller with hand-computed expectations.
module tb_alarm_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ignition = 1'b0;
   logic       driverDoor = 1'b0;
   logic       passengerDoor = 1'b0;
   logic       reprogram = 1'b0;
   logic [1:0] timeParamSel = 2'd0;
   logic [3:0] timeValue = 4'd0;
   logic       expired = 1'b0;
   logic       blink1Hz = 1'b0;
   logic       startTimer;
   logic [3:0] value;
   logic       siren;
   logic       statusIndicator;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int n_start  = 0;
   int snap;

   alarm_controller dut (
      .clock           (clock),
      .reset           (reset),
      .ignition        (ignition),
      .driverDoor      (driverDoor),
      .passengerDoor   (passengerDoor),
      .reprogram       (reprogram),
      .timeParamSel    (timeParamSel),
      .timeValue       (timeValue),
      .expired         (expired),
      .blink1Hz        (blink1Hz),
      .startTimer      (startTimer),
      .value           (value),
      .siren           (siren),
      .statusIndicator (statusIndicator),
      .state           (state)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (startTimer === 1'b1) n_start++;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ignition = 1'b0; driverDoor = 1'b0; passengerDoor = 1'b0;
      reprogram = 1'b0; expired = 1'b0; blink1Hz = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
      n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", startTimer); end
      n_checks++; if (value !== 4'd0) begin n_fail++; $display("FAIL reset_value got=%0d exp=0", value); end
      n_checks++; if (siren !== 1'b0) begin n_fail++; $display("FAIL reset_siren got=%b exp=0", siren); end
      n_checks++; if (statusIndicator !== 1'b0) begin n_fail++; $display("FAIL reset_status got=%b exp=0", statusIndicator); end
      blink1Hz = 1'b1; tick();
      n_checks++; if (statusIndicator !== 1'b1) begin n_fail++; $display("FAIL armed_blink_hi got=%b exp=1", statusIndicator); end
      blink1Hz = 1'b0; tick();
      n_checks++; if (statusIndicator !== 1'b0) begin n_fail++; $display("FAIL armed_blink_lo got=%b exp=0", statusIndicator); end
   endtask

   task automatic test_driver_trigger();
      do_reset();
      driverDoor = 1'b1; tick();
      n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL trig_state got=%0d exp=1", state); end
      n_checks++; if (startTimer !== 1'b1) begin n_fail++; $display("FAIL trig_start got=%b exp=1", startTimer); end
      n_checks++; if (value !== 4'd8) begin n_fail++; $display("FAIL trig_value got=%0d exp=8", value); end
      n_checks++; if (statusIndicator !== 1'b1) begin n_fail++; $display("FAIL trig_status got=%b exp=1", statusIndicator); end
      expired = 1'b1; tick();
      n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL expired_in_start_cycle got=%0d exp=1", state); end
      n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle got=%b exp=0", startTimer); end
      tick();
      expired = 1'b0;
      n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL sound_state got=%0d exp=2", state); end
      n_checks++; if (siren !== 1'b1) begin n_fail++; $display("FAIL sound_siren got=%b exp=1", siren); end
   endtask

   task automatic test_sound_hold();
      snap = n_start;
      driverDoor = 1'b0; tick();
      n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL hold_state got=%0d exp=3", state); end
      n_checks++; if (value !== 4'd10) begin n_fail++; $display("FAIL hold_value got=%0d exp=10", value); end
      n_checks++; if (startTimer !== 1'b1) begin n_fail++; $display("FAIL hold_start got=%b exp=1", startTimer); end
      n_checks++; if (siren !== 1'b1) begin n_fail++; $display("FAIL hold_siren got=%b exp=1", siren); end
      passengerDoor = 1'b1; tick();
      n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL reopen_state got=%0d exp=2", state); end
      passengerDoor = 1'b0; tick();
      n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL reclose_state got=%0d exp=3", state); end
      tick();
      expired = 1'b1; tick();
      expired = 1'b0;
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL hold_expire_state got=%0d exp=0", state); end
      n_checks++; if (siren !== 1'b0) begin n_fail++; $display("FAIL hold_expire_siren got=%b exp=0", siren); end
      n_checks++; if (n_start - snap !== 2) begin n_fail++; $display("FAIL hold_pulse_count got=%0d exp=2", n_start - snap); end
   endtask

   task automatic test_passenger_disarm();
      do_reset();
      passengerDoor = 1'b1; tick();
      n_checks++; if (value !== 4'd15) begin n_fail++; $display("FAIL pass_value got=%0d exp=15", value); end
      n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL pass_state got=%0d exp=1", state); end
      ignition = 1'b1; expired = 1'b1; tick();
      snap = n_start;
      n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL disarm_state got=%0d exp=4", state); end
      n_checks++; if (siren !== 1'b0) begin n_fail++; $display("FAIL disarm_siren got=%b exp=0", siren); end
      tick(); tick();
      expired = 1'b0;
      n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL disarm_hold got=%0d exp=4", state); end
      n_checks++; if (n_start !== snap) begin n_fail++; $display("FAIL disarm_no_start got=%0d exp=%0d", n_start, snap); end
      n_checks++; if (statusIndicator !== 1'b0) begin n_fail++; $display("FAIL disarm_status got=%b exp=0", statusIndicator); end
   endtask

   task automatic test_disarm_sequence();
      passengerDoor = 1'b0; ignition = 1'b0; tick();
      n_checks++; if (state !== 3'd5) begin n_fail++; $display("FAIL wait_open got=%0d exp=5", state); end
      driverDoor = 1'b1; tick();
      n_checks++; if (state !== 3'd6) begin n_fail++; $display("FAIL wait_close got=%0d exp=6", state); end
      driverDoor = 1'b0; tick();
      n_checks++; if (state !== 3'd7) begin n_fail++; $display("FAIL arm_delay got=%0d exp=7", state); end
      n_checks++; if (value !== 4'd6) begin n_fail++; $display("FAIL arm_value got=%0d exp=6", value); end
      n_checks++; if (startTimer !== 1'b1) begin n_fail++; $display("FAIL arm_start got=%b exp=1", startTimer); end
      driverDoor = 1'b1; tick();
      n_checks++; if (state !== 3'd6) begin n_fail++; $display("FAIL arm_reopen got=%0d exp=6", state); end
      driverDoor = 1'b0; tick(); tick();
      expired = 1'b1; tick();
      expired = 1'b0;
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rearm_state got=%0d exp=0", state); end
   endtask

   task automatic test_reprogram();
      do_reset();
      reprogram = 1'b1; timeParamSel = 2'd1; timeValue = 4'd3; tick();
      reprogram = 1'b0;
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reprog_state got=%0d exp=0", state); end
      n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL reprog_start got=%b exp=0", startTimer); end
      expired = 1'b1; tick();
      expired = 1'b0;
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL armed_ignore_expired got=%0d exp=0", state); end
      driverDoor = 1'b1; tick();
      n_checks++; if (value !== 4'd3) begin n_fail++; $display("FAIL reprog_value got=%0d exp=3", value); end
      reprogram = 1'b1; timeParamSel = 2'd3; timeValue = 4'd2; tick();
      reprogram = 1'b0;
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reprog_force_armed got=%0d exp=0", state); end
      n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL reprog_force_start got=%b exp=0", startTimer); end
      tick();
      n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL retrigger got=%0d exp=1", state); end
      tick();
      expired = 1'b1; tick();
      expired = 1'b0;
      driverDoor = 1'b0; tick();
      n_checks++; if (value !== 4'd2) begin n_fail++; $display("FAIL reprog_alarm_on got=%0d exp=2", value); end
   endtask

   task automatic test_reset_mid();
      ignition = 1'b1; tick();
      ignition = 1'b0; tick();
      driverDoor = 1'b1; tick();
      driverDoor = 1'b0; tick();
      n_checks++; if (state !== 3'd7) begin n_fail++; $display("FAIL mid_arm_delay got=%0d exp=7", state); end
      reset = 1'b1; #2;
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL async_state got=%0d exp=0", state); end
      n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL async_start got=%b exp=0", startTimer); end
      n_checks++; if (value !== 4'd0) begin n_fail++; $display("FAIL async_value got=%0d exp=0", value); end
      n_checks++; if (siren !== 1'b0 || statusIndicator !== 1'b0) begin n_fail++; $display("FAIL async_outs got=%b%b exp=00", siren, statusIndicator); end
      tick();
      reset = 1'b0;
      snap = n_start;
      expired = 1'b1; tick();
      expired = 1'b0; tick();
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_expired got=%0d exp=0", state); end
      n_checks++; if (n_start !== snap) begin n_fail++; $display("FAIL post_reset_start got=%0d exp=%0d", n_start, snap); end
      driverDoor = 1'b1; tick();
      driverDoor = 1'b0;
      n_checks++; if (value !== 4'd8) begin n_fail++; $display("FAIL defaults_restored got=%0d exp=8", value); end
   endtask

   initial begin
      test_reset();
      test_driver_trigger();
      test_sound_hold();
      test_passenger_disarm();
      test_disarm_sequence();
      test_reprogram();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter T_ARM_DELAY, default 6: seconds from driver-door close to re-arm.
REQ-002 Parameter T_DRIVER_DELAY, default 8: seconds from driver-door open to siren.
REQ-003 Parameter T_PASSENGER_DELAY, default 15: seconds from passenger-door open to siren.
REQ-004 Parameter T_ALARM_ON, default 10: seconds the siren holds after all doors close.
REQ-005 Ports SHALL be: clock in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-006 ignition in 1, key on; driverDoor in 1, driver door open; passengerDoor in 1, passenger door open.
REQ-007 reprogram in 1, write strobe; timeParamSel in 2, 0=arm, 1=driver, 2=passenger, 3=alarm-on; timeValue in 4, new interval.
REQ-008 expired in 1, one-cycle pulse from the 1 Hz timer; blink1Hz in 1, 1 Hz square wave from the timer.
REQ-009 startTimer out 1, one-cycle start pulse; value out 4, interval to the timer; siren out 1; statusIndicator out 1; state out 3, current state code.

Function
REQ-010 Four 4-bit interval registers SHALL hold arm/driver/passenger/alarm-on intervals, loaded from parameters at reset.
REQ-011 reprogram=1 SHALL write timeValue into the register selected by timeParamSel and force the next state to ARMED, with no startTimer issued.
REQ-012 States: ARMED=0, TRIGGERED=1, SOUND=2, ALARM_HOLD=3, DISARMED=4, WAIT_OPEN=5, WAIT_CLOSE=6, ARM_DELAY=7.
REQ-013 ARMED: door open -> TRIGGERED, value=driver interval if driverDoor=1 (priority), else passenger interval.
REQ-014 TRIGGERED: ignition=1 -> DISARMED (priority over expired); expired -> SOUND.
REQ-015 SOUND: ignition=1 -> DISARMED; both doors closed -> ALARM_HOLD, value=alarm-on interval.
REQ-016 ALARM_HOLD: ignition=1 -> DISARMED; any door open -> SOUND, timer abandoned; expired -> ARMED.
REQ-017 DISARMED: ignition=0 -> WAIT_OPEN. WAIT_OPEN: ignition=1 -> DISARMED; driverDoor=1 -> WAIT_CLOSE.
REQ-018 WAIT_CLOSE: ignition=1 -> DISARMED; driverDoor=0 -> ARM_DELAY, value=arm interval.
REQ-019 ARM_DELAY: ignition=1 -> DISARMED; driverDoor=1 -> WAIT_CLOSE; expired -> ARMED.
REQ-020 startTimer SHALL pulse for exactly one cycle, registered, in the first cycle of each entry into TRIGGERED, ALARM_HOLD and ARM_DELAY, and never otherwise.
REQ-021 value SHALL be updated in the same cycle as startTimer and held stable until the next startTimer.
REQ-022 expired SHALL be ignored outside TRIGGERED, ALARM_HOLD and ARM_DELAY, and in the cycle startTimer is high.
REQ-023 siren SHALL be 1 in SOUND and ALARM_HOLD only.
REQ-024 statusIndicator SHALL follow blink1Hz in ARMED, be 1 in TRIGGERED, SOUND and ALARM_HOLD, and be 0 otherwise.
REQ-025 All outputs SHALL be registered; transitions SHALL take effect one clock after the qualifying input is sampled.

Reset
REQ-026 reset=1 SHALL immediately force: state ARMED, startTimer 0, value 0, siren 0, statusIndicator 0, interval registers to parameter defaults.
REQ-027 reset mid-countdown SHALL abandon the timer; no startTimer is issued on reset release.

Structure
REQ-028 A shared package SHALL hold the state encodings, timeParamSel codes and default interval constants.
REQ-029 One sub-module, time_parameters, SHALL hold the interval register file and the reprogram write logic, with selected-interval read ports.

Verification
REQ-030 Reset, then driverDoor=1 -> next cycle: state=1, startTimer one pulse, value=8; one expired -> state=2, siren=1.
REQ-031 From ARMED, passengerDoor=1 -> value=15; ignition=1 before expired -> state=4, siren=0, no further startTimer.
REQ-032 In SOUND, close both doors -> state=3, value=10, startTimer pulse; reopen passengerDoor -> state=2; close, then expired -> state=0.
REQ-033 Disarm sequence: ignition 1->0, driverDoor 1->0 -> state=7, value=6; reopen driverDoor -> state=6; close, expired -> state=0.
REQ-034 reprogram with timeParamSel=1, timeValue=3 -> state=0; then driverDoor=1 -> value=3; expired in ARMED -> no change.
REQ-035 Assert reset during ARM_DELAY -> state=0 and all outputs at reset values; an expired after release -> no change.
